ex_trap_plic: RTL and testbench



---
 rtl/ex_trap_plic.sv | 234 +++++++++++++++++++++++
 tb/tb_ex_trap_plic.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_trap_plic.sv
// ex_trap_plic: prioritised external-interrupt controller for the core trap port.
// Define PLIC_EDGE_EN to add per-source rising-edge triggering at offset 0x90.
module ex_trap_plic #(
  parameter int SRC_NUM = 16,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SRC_NUM-1:0] src_i,
  output logic               ex_trap_valid_o,
  output logic [4:0]         ex_trap_id_o,
  input  logic               ex_trap_ready_i,
  input  logic               ex_trap_cplet_i,
  input  logic [4:0]         ex_trap_cplet_id_i,
  input  logic               plic_icb_cmd_valid,
  output logic               plic_icb_cmd_ready,
  input  logic [31:0]        plic_icb_cmd_addr,
  input  logic               plic_icb_cmd_read,
  input  logic [31:0]        plic_icb_cmd_wdata,
  input  logic [3:0]         plic_icb_cmd_wmask,
  output logic               plic_icb_rsp_valid,
  input  logic               plic_icb_rsp_ready,
  output logic               plic_icb_rsp_err,
  output logic [31:0]        plic_icb_rsp_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  localparam logic [SRC_NUM:0] SRC_MASK = {{SRC_NUM{1'b1}}, 1'b0};

  state_t             state;
  logic [SRC_NUM-1:0] sync1, sync2;
  logic [SRC_NUM:0]   lvl, busy, fire, clr;
  logic [SRC_NUM:0]   pend_q, en_q;
  logic [PRIO_W-1:0]  prio_q [32];
  logic [PRIO_W-1:0]  thr_q;
  logic [4:0]         isr_q;
  logic [4:0]         best_id;
  logic [PRIO_W-1:0]  best_pr;

`ifdef PLIC_EDGE_EN
  logic [SRC_NUM-1:0] sync3;
  logic [SRC_NUM:0]   type_q, lat_q, edg;
`endif

  assign lvl = {sync2, 1'b0};

  // A source is busy while pending or being serviced; it cannot re-fire.
  always_comb begin
    busy = '0;
    for (int i = 0; i <= SRC_NUM; i++) begin
      busy[i] = pend_q[i] || (isr_q == 5'(i));
    end
`ifdef PLIC_EDGE_EN
    edg  = lvl & ~{sync3, 1'b0};
    fire = ((type_q & (edg | lat_q)) | (~type_q & lvl)) & ~busy;
`else
    fire = lvl & ~busy;
`endif
  end

  always_comb begin
    clr = '0;
    if (state == REQ && ex_trap_ready_i) begin
      clr = {{SRC_NUM{1'b0}}, 1'b1} << ex_trap_id_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      pend_q <= '0;
    end else begin
      sync1  <= src_i;
      sync2  <= sync1;
      pend_q <= (pend_q | fire) & ~clr;
    end
  end

`ifdef PLIC_EDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync3 <= '0;
      lat_q <= '0;
    end else begin
      sync3 <= sync2;
      lat_q <= (lat_q | (type_q & edg & busy)) & ~fire;
    end
  end
`endif

  // Descending scan with >= leaves the lowest ID on priority ties.
  always_comb begin
    best_id = '0;
    best_pr = '0;
    for (int i = SRC_NUM; i >= 1; i--) begin
      if (pend_q[i] && en_q[i] && (prio_q[i] > thr_q)
          && (prio_q[i] >= best_pr)) begin
        best_id = 5'(i);
        best_pr = prio_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ex_trap_valid_o <= 1'b0;
      ex_trap_id_o    <= '0;
      isr_q           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (best_id != '0) begin
            ex_trap_id_o    <= best_id;
            ex_trap_valid_o <= 1'b1;
            state           <= REQ;
          end
        end
        REQ: begin
          if (ex_trap_ready_i) begin
            ex_trap_valid_o <= 1'b0;
            isr_q           <= ex_trap_id_o;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (ex_trap_cplet_i && ex_trap_cplet_id_i == isr_q) begin
            isr_q <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [5:0]  widx;
  logic [31:0] bm, rd;
  logic        sel_prio, sel_pend, sel_en, sel_thr, sel_isr;
  logic        mapped, dec_err, hs, wr;
  logic        unused_ok;

  assign widx = plic_icb_cmd_addr[7:2];
  assign bm   = {{8{plic_icb_cmd_wmask[3]}}, {8{plic_icb_cmd_wmask[2]}},
                 {8{plic_icb_cmd_wmask[1]}}, {8{plic_icb_cmd_wmask[0]}}};
  assign unused_ok = ^{plic_icb_cmd_addr[31:8], plic_icb_cmd_addr[1:0],
                       plic_icb_cmd_wdata, bm};

  assign sel_prio = !widx[5] && ({1'b0, widx[4:0]} <= 6'(SRC_NUM));
  assign sel_pend = widx == 6'h20;
  assign sel_en   = widx == 6'h21;
  assign sel_thr  = widx == 6'h22;
  assign sel_isr  = widx == 6'h23;

`ifdef PLIC_EDGE_EN
  logic sel_type;
  assign sel_type = widx == 6'h24;
  assign mapped   = sel_prio | sel_pend | sel_en | sel_thr | sel_isr | sel_type;
`else
  assign mapped   = sel_prio | sel_pend | sel_en | sel_thr | sel_isr;
`endif

  assign dec_err = !mapped || (!plic_icb_cmd_read && (sel_pend || sel_isr));
  assign plic_icb_cmd_ready = !plic_icb_rsp_valid || plic_icb_rsp_ready;
  assign hs = plic_icb_cmd_valid && plic_icb_cmd_ready;
  assign wr = hs && !plic_icb_cmd_read && !dec_err;

  always_comb begin
    rd = '0;
    unique case (1'b1)
      sel_prio: rd = 32'(prio_q[widx[4:0]]);
      sel_pend: rd = 32'(pend_q);
      sel_en:   rd = 32'(en_q);
      sel_thr:  rd = 32'(thr_q);
      sel_isr:  rd = 32'(isr_q);
`ifdef PLIC_EDGE_EN
      sel_type: rd = 32'(type_q);
`endif
      default:  rd = '0;
    endcase
  end

  // Entry 0 and entries above SRC_NUM are never written and stay zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) prio_q[i] <= '0;
      en_q  <= '0;
      thr_q <= '0;
`ifdef PLIC_EDGE_EN
      type_q <= '0;
`endif
    end else if (wr) begin
      if (sel_prio && widx[4:0] != '0) begin
        prio_q[widx[4:0]] <= (prio_q[widx[4:0]] & ~bm[PRIO_W-1:0])
                           | (plic_icb_cmd_wdata[PRIO_W-1:0] & bm[PRIO_W-1:0]);
      end
      if (sel_en) begin
        en_q <= ((en_q & ~bm[SRC_NUM:0])
               | (plic_icb_cmd_wdata[SRC_NUM:0] & bm[SRC_NUM:0])) & SRC_MASK;
      end
      if (sel_thr) begin
        thr_q <= (thr_q & ~bm[PRIO_W-1:0])
               | (plic_icb_cmd_wdata[PRIO_W-1:0] & bm[PRIO_W-1:0]);
      end
`ifdef PLIC_EDGE_EN
      if (sel_type) begin
        type_q <= ((type_q & ~bm[SRC_NUM:0])
                 | (plic_icb_cmd_wdata[SRC_NUM:0] & bm[SRC_NUM:0])) & SRC_MASK;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plic_icb_rsp_valid <= 1'b0;
      plic_icb_rsp_err   <= 1'b0;
      plic_icb_rsp_rdata <= '0;
    end else if (hs) begin
      plic_icb_rsp_valid <= 1'b1;
      plic_icb_rsp_err   <= dec_err;
      plic_icb_rsp_rdata <= plic_icb_cmd_read ? rd : '0;
    end else if (plic_icb_rsp_ready) begin
      plic_icb_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_trap_plic.sv
// tb_ex_trap_plic: directed plus randomized checks of ex_trap_plic.
// Edge-trigger steps are built only when PLIC_EDGE_EN is defined.
module tb_ex_trap_plic;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] src_i = '0;
  logic        ex_trap_valid_o;
  logic [4:0]  ex_trap_id_o;
  logic        ex_trap_ready_i = 1'b0;
  logic        ex_trap_cplet_i = 1'b0;
  logic [4:0]  ex_trap_cplet_id_i = '0;
  logic        plic_icb_cmd_valid = 1'b0;
  logic        plic_icb_cmd_ready;
  logic [31:0] plic_icb_cmd_addr = '0;
  logic        plic_icb_cmd_read = 1'b0;
  logic [31:0] plic_icb_cmd_wdata = '0;
  logic [3:0]  plic_icb_cmd_wmask = '0;
  logic        plic_icb_rsp_valid;
  logic        plic_icb_rsp_ready = 1'b1;
  logic        plic_icb_rsp_err;
  logic [31:0] plic_icb_rsp_rdata;

  int checks = 0;
  int errors = 0;
  int pr [32];

  ex_trap_plic #(.SRC_NUM(16), .PRIO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .src_i(src_i),
    .ex_trap_valid_o(ex_trap_valid_o), .ex_trap_id_o(ex_trap_id_o),
    .ex_trap_ready_i(ex_trap_ready_i), .ex_trap_cplet_i(ex_trap_cplet_i),
    .ex_trap_cplet_id_i(ex_trap_cplet_id_i),
    .plic_icb_cmd_valid(plic_icb_cmd_valid),
    .plic_icb_cmd_ready(plic_icb_cmd_ready),
    .plic_icb_cmd_addr(plic_icb_cmd_addr),
    .plic_icb_cmd_read(plic_icb_cmd_read),
    .plic_icb_cmd_wdata(plic_icb_cmd_wdata),
    .plic_icb_cmd_wmask(plic_icb_cmd_wmask),
    .plic_icb_rsp_valid(plic_icb_rsp_valid),
    .plic_icb_rsp_ready(plic_icb_rsp_ready),
    .plic_icb_rsp_err(plic_icb_rsp_err),
    .plic_icb_rsp_rdata(plic_icb_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_i = '0;
    ex_trap_ready_i = 1'b0;
    ex_trap_cplet_i = 1'b0;
    plic_icb_cmd_valid = 1'b0;
    plic_icb_rsp_ready = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic icb(input logic rd, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m,
                     output logic [31:0] q, output logic e);
    int n;
    plic_icb_cmd_valid = 1'b1;
    plic_icb_cmd_read  = rd;
    plic_icb_cmd_addr  = a;
    plic_icb_cmd_wdata = d;
    plic_icb_cmd_wmask = m;
    plic_icb_rsp_ready = 1'b1;
    n = 0;
    while (!plic_icb_cmd_ready && n < 20) begin
      step(1);
      n++;
    end
    step(1);
    plic_icb_cmd_valid = 1'b0;
    n = 0;
    while (!plic_icb_rsp_valid && n < 20) begin
      step(1);
      n++;
    end
    chk("icb_rsp_seen", plic_icb_rsp_valid, 1);
    q = plic_icb_rsp_rdata;
    e = plic_icb_rsp_err;
    step(1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    logic e;
    icb(1'b0, a, d, 4'hF, q, e);
    chk("cfg_wr_err", e, 0);
  endtask

  task automatic wait_valid(input int max, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      if (ex_trap_valid_o) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic accept();
    ex_trap_ready_i = 1'b1;
    step(1);
    ex_trap_ready_i = 1'b0;
  endtask

  task automatic complete(input logic [4:0] id);
    ex_trap_cplet_i = 1'b1;
    ex_trap_cplet_id_i = id;
    step(1);
    ex_trap_cplet_i = 1'b0;
  endtask

  // Reference arbiter: highest priority wins, first (lowest) ID on a tie.
  function automatic int pick(input logic [31:0] s);
    int b = 0;
    int bp = 0;
    for (int id = 1; id <= 16; id++) begin
      if (s[id] && pr[id] > bp) begin
        b = id;
        bp = pr[id];
      end
    end
    return b;
  endfunction

  initial begin
    logic [31:0] q, q0, en, raised, elig, rem;
    logic e, ok;
    int thr, x;

    do_reset();
    chk("rst_valid", ex_trap_valid_o, 0);
    chk("rst_id", ex_trap_id_o, 0);
    chk("rst_cmd_ready", plic_icb_cmd_ready, 1);
    icb(1'b1, 32'h80, 0, 0, q, e); chk("rst_pend", q, 0);
    icb(1'b1, 32'h84, 0, 0, q, e); chk("rst_en", q, 0);
    icb(1'b1, 32'h88, 0, 0, q, e); chk("rst_thr", q, 0);
    icb(1'b1, 32'h8C, 0, 0, q, e); chk("rst_isr", q, 0);

    wr(32'h0C, 2); wr(32'h14, 2); wr(32'h84, 32'h28); wr(32'h88, 1);
    src_i = 16'h0014;
    wait_valid(20, ok); chk("tie_valid", ok, 1);
    chk("tie_id3", ex_trap_id_o, 3);
    accept();
    chk("tie_drop", ex_trap_valid_o, 0);
    src_i[2] = 1'b0;
    icb(1'b1, 32'h80, 0, 0, q, e); chk("tie_pend5", q, 32'h20);
    complete(3);
    wait_valid(20, ok); chk("tie_valid5", ok, 1);
    chk("tie_id5", ex_trap_id_o, 5);
    accept();
    src_i[4] = 1'b0;
    icb(1'b1, 32'h8C, 0, 0, q, e); chk("tie_isr5", q, 5);
    complete(5);

    wr(32'h10, 2); wr(32'h84, 32'h38); wr(32'h88, 2);
    src_i[3] = 1'b1;
    step(8);
    chk("thr_block", ex_trap_valid_o, 0);
    icb(1'b1, 32'h80, 0, 0, q, e); chk("thr_pend4", q, 32'h10);
    wr(32'h88, 1);
    chk("thr_valid", ex_trap_valid_o, 1);
    chk("thr_id4", ex_trap_id_o, 4);
    accept();
    src_i[3] = 1'b0;
    step(3);
    complete(4);

    wr(32'h18, 3); wr(32'h84, 32'h78);
    src_i[5] = 1'b1;
    wait_valid(20, ok); chk("hold_valid", ok, 1);
    chk("hold_id6", ex_trap_id_o, 6);
    wr(32'h84, 32'h38);
    chk("hold_en_v", ex_trap_valid_o, 1);
    chk("hold_en_id", ex_trap_id_o, 6);
    wr(32'h88, 7);
    chk("hold_thr_v", ex_trap_valid_o, 1);
    chk("hold_thr_id", ex_trap_id_o, 6);
    accept();
    src_i[5] = 1'b0;
    chk("hold_drop", ex_trap_valid_o, 0);
    step(3);
    complete(7);
    step(2);
    chk("cplet7_valid", ex_trap_valid_o, 0);
    icb(1'b1, 32'h8C, 0, 0, q, e); chk("cplet7_isr", q, 6);
    complete(6);
    icb(1'b1, 32'h8C, 0, 0, q, e); chk("cplet6_isr", q, 0);

    icb(1'b0, 32'h80, 32'hFFFF, 4'hF, q, e); chk("err_wr80", e, 1);
    icb(1'b1, 32'h80, 0, 0, q, e); chk("err_pend_kept", q, 0);
    icb(1'b0, 32'h8C, 32'h3, 4'hF, q, e); chk("err_wr8c", e, 1);
    icb(1'b1, 32'hA0, 0, 0, q, e); chk("err_rdA0", e, 1);
    chk("err_rdA0_data", q, 0);
    icb(1'b0, 32'h44, 32'h7, 4'hF, q, e); chk("err_prio17", e, 1);
    icb(1'b0, 32'h00, 32'h7, 4'hF, q, e); chk("prio0_wr_err", e, 0);
    icb(1'b1, 32'h00, 0, 0, q, e); chk("prio0_rd", q, 0);
    icb(1'b0, 32'h04, 32'h5, 4'h0, q, e);
    icb(1'b1, 32'h04, 0, 0, q, e); chk("wmask0", q, 0);
    icb(1'b0, 32'h04, 32'h5, 4'h1, q, e);
    icb(1'b1, 32'h04, 0, 0, q, e); chk("wmask1", q, 5);

    plic_icb_rsp_ready = 1'b0;
    plic_icb_cmd_valid = 1'b1;
    plic_icb_cmd_read  = 1'b1;
    plic_icb_cmd_addr  = 32'h84;
    step(1);
    plic_icb_cmd_valid = 1'b0;
    chk("stall_rsp_v", plic_icb_rsp_valid, 1);
    q0 = plic_icb_rsp_rdata;
    chk("stall_data", q0, 32'h38);
    for (int i = 0; i < 3; i++) begin
      chk("stall_cmd_rdy", plic_icb_cmd_ready, 0);
      chk("stall_rsp_hold", plic_icb_rsp_valid, 1);
      chk("stall_data_hold", plic_icb_rsp_rdata, q0);
      step(1);
    end
    plic_icb_rsp_ready = 1'b1;
    step(1);
    chk("stall_release", plic_icb_rsp_valid, 0);

    wr(32'h84, 32'h02); wr(32'h88, 0);
    src_i[0] = 1'b1;
    wait_valid(20, ok); chk("arst_valid", ok, 1);
    chk("arst_id1", ex_trap_id_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_drop", ex_trap_valid_o, 0);
    chk("arst_id0", ex_trap_id_o, 0);
    src_i = '0;
    step(2);
    rst_n = 1'b1;
    step(1);

`ifdef PLIC_EDGE_EN
    wr(32'h90, 32'h4);
    icb(1'b1, 32'h90, 0, 0, q, e); chk("edge_type_rd", q, 4);
    wr(32'h08, 1); wr(32'h84, 32'h04);
    src_i[1] = 1'b1; step(3); src_i[1] = 1'b0;
    wait_valid(20, ok); chk("edge_first", ok, 1);
    chk("edge_id2", ex_trap_id_o, 2);
    accept();
    for (int i = 0; i < 2; i++) begin
      src_i[1] = 1'b1; step(3); src_i[1] = 1'b0; step(3);
    end
    chk("edge_busy", ex_trap_valid_o, 0);
    complete(2);
    wait_valid(20, ok); chk("edge_redeliver", ok, 1);
    chk("edge_re_id", ex_trap_id_o, 2);
    accept();
    step(3);
    complete(2);
    step(10);
    chk("edge_once", ex_trap_valid_o, 0);
`else
    icb(1'b0, 32'h90, 32'h4, 4'hF, q, e); chk("no_edge_err", e, 1);
`endif

    for (int r = 0; r < 4; r++) begin
      do_reset();
      chk("rnd_rst_valid", ex_trap_valid_o, 0);
      en = ($urandom() & 32'hFFFF) << 1;
      thr = $urandom_range(0, 3);
      pr[0] = 0;
      for (int id = 1; id <= 16; id++) begin
        pr[id] = $urandom_range(0, 7);
        wr(32'(4 * id), 32'(pr[id]));
      end
      wr(32'h84, en);
      wr(32'h88, 32'(thr));
      raised = ($urandom() & 32'hFFFF) << 1;
      if (raised == 0) raised = 32'h2;
      elig = '0;
      for (int id = 1; id <= 16; id++) begin
        if (raised[id] && en[id] && pr[id] > thr) elig[id] = 1'b1;
      end
      src_i = raised[16:1];
      rem = elig;
      while (rem != 0) begin
        x = pick(rem);
        wait_valid(20, ok);
        chk("rnd_valid", ok, 1);
        if (!ok) break;
        chk("rnd_id", ex_trap_id_o, 32'(x));
        accept();
        src_i[x-1] = 1'b0;
        rem[x] = 1'b0;
        step(4);
        complete(5'(x));
      end
      step(10);
      chk("rnd_idle", ex_trap_valid_o, 0);
      icb(1'b1, 32'h80, 0, 0, q, e);
      chk("rnd_pend_left", q, raised & ~elig);
      src_i = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
